// File: rtl/core_pkg.sv
// Types, constants and helpers shared by the fetch-stage PC generator and
// its redirect latch.
package core_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        PEND_JUMP,
        PEND_TRAP
    } pend_e;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    // The mask has ones in every bit except the low 'bits' bits.
    function automatic logic [63:0] align_mask(input int unsigned bits);
        return ~((64'd1 << bits) - 64'd1);
    endfunction

endpackage

// File: rtl/redirect_latch.sv
// Holds one redirect that arrives while fetch is stalled. A trap always wins,
// and a newer jump replaces an older jump. The latch empties on any non-stall cycle.
module redirect_latch
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_pc,
    output pend_e           pend_state,
    output logic [XLEN-1:0] pend_target,
    output logic            pending
);

    pend_e           state_reg, state_next;
    logic [XLEN-1:0] target_reg, target_next;

    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        if (!stall) begin
            // In this cycle the entry is either applied or replaced by a live redirect.
            state_next = EMPTY;
        end else if (trap_valid) begin
            state_next  = PEND_TRAP;
            target_next = trap_pc;
        end else if (jump_valid && state_reg != PEND_TRAP) begin
            state_next  = PEND_JUMP;
            target_next = jump_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= EMPTY;
            target_reg <= '0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
        end
    end

    assign pend_state  = state_reg;
    assign pend_target = target_reg;
    assign pending     = (state_reg != EMPTY);

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator. It selects trap, jump, pending or predicted PC each cycle,
// forces alignment, flags misaligned targets and counts applied redirects.
module pc_gen
    import core_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned ALIGN_BITS = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regF_stall,
    input  logic             trap_i_valid,
    input  logic [XLEN-1:0]  trap_i_pc,
    input  logic             execute_i_need_jump,
    input  logic [XLEN-1:0]  execute_i_jump_pc,
    input  logic [XLEN-1:0]  fetch_i_pre_pc,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    output logic             pc_misaligned,
    output logic             redirect_pending,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [63:0]     ALIGN_MASK_FULL = align_mask(ALIGN_BITS);
    localparam logic [XLEN-1:0] ALIGN_MASK      = ALIGN_MASK_FULL[XLEN-1:0];
    localparam logic [XLEN-1:0] PC_AT_RESET     = RESET_PC[XLEN-1:0];

    pend_e           pend_state;
    logic [XLEN-1:0] pend_target;
    logic            pend_any;

    logic [XLEN-1:0]  pc_reg;
    logic             valid_reg;
    logic             misaligned_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [XLEN-1:0] load_target;
    logic            load_is_redirect;

    redirect_latch #(
        .XLEN (XLEN)
    ) u_redirect_latch (
        .clk         (clk),
        .rst         (rst),
        .stall       (regF_stall),
        .trap_valid  (trap_i_valid),
        .trap_pc     (trap_i_pc),
        .jump_valid  (execute_i_need_jump),
        .jump_pc     (execute_i_jump_pc),
        .pend_state  (pend_state),
        .pend_target (pend_target),
        .pending     (pend_any)
    );

    always_comb begin
        load_target      = fetch_i_pre_pc;
        load_is_redirect = 1'b0;
        if (trap_i_valid) begin
            load_target      = trap_i_pc;
            load_is_redirect = 1'b1;
        end else if (execute_i_need_jump) begin
            load_target      = execute_i_jump_pc;
            load_is_redirect = 1'b1;
        end else if (pend_state != EMPTY) begin
            load_target      = pend_target;
            load_is_redirect = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg         <= PC_AT_RESET;
            valid_reg      <= 1'b0;
            misaligned_reg <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            valid_reg <= 1'b1;
            if (regF_stall) begin
                misaligned_reg <= 1'b0;
            end else begin
                pc_reg         <= load_target & ALIGN_MASK;
                misaligned_reg <= |(load_target & ~ALIGN_MASK);
                if (load_is_redirect) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign pc               = pc_reg;
    assign pc_valid         = valid_reg;
    assign pc_misaligned    = misaligned_reg;
    assign redirect_pending = pend_any;
    assign redirect_cnt     = cnt_reg;

endmodule
